csi_rx_packet_handler: RTL and testbench

Consumes lane-aligned words from the word aligner, parses the 4-byte CSI-2 packet header (DI, WC_lo, WC_hi, ECC) and tracks frame/line state from short packets. Strips header and CRC bytes from long packets and delivers payload bytes with per-lane byte enables to the downstream pixel unpacker. Returns `packet_done` and `wait_for_sync` to the aligner, closing the resync loop.

---
 rtl/csi_rx_packet_handler.sv | 175 +++++++++++++++++
 tb/tb_csi_rx_packet_handler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 RX packet handler: parses packet headers, tracks frame/line state and strips payload.
// Optional macro CSI_RX_ECC_CHECK_EN enables checking of the 6-bit header ECC.
module csi_rx_packet_handler #(
  parameter int unsigned NUM_LANE = 2,
  parameter logic [1:0]  VC_SEL   = 2'd0,
  parameter logic [15:0] MAX_WC   = 16'd8192
) (
  input  logic                  byte_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_LANE*8-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  wait_for_sync,
  output logic                  packet_done,
  output logic [NUM_LANE*8-1:0] payload_out,
  output logic [NUM_LANE-1:0]   payload_be,
  output logic                  payload_valid,
  output logic [5:0]            data_type,
  output logic                  in_frame,
  output logic                  in_line,
  output logic                  hdr_err
);
  localparam int unsigned W         = NUM_LANE * 8;
  localparam int unsigned HDR_WORDS = 4 / NUM_LANE;
  localparam int unsigned LOG_NL    = $clog2(NUM_LANE);
  localparam logic [1:0]  HDR_LAST  = 2'(HDR_WORDS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state_q, state_d, hdr_next_state;
  logic          valid_q;
  logic [31:0]   hdr_q, hdr_d;
  logic [1:0]    hdr_idx_q, cur_idx;
  logic [15:0]   wc_q, byte_cnt_q, words_left_q;
  logic          vc_ok_q;
  logic [W-1:0]  payload_q;
  logic [NUM_LANE-1:0] be_q, lane_be;
  logic [5:0]    data_type_q;
  logic          in_frame_q, in_line_q, hdr_err_q;

  logic          rise, hdr_accept, hdr_last, hdr_decode;
  logic [1:0]    vc;
  logic [5:0]    dt;
  logic [15:0]   wc;
  logic          is_short, wc_too_big, ecc_bad;
  logic [16:0]   wc_words, byte_cnt_sum;

  assign rise       = data_valid_in && !valid_q;
  assign cur_idx    = (state_q == IDLE) ? 2'd0 : hdr_idx_q;
  assign hdr_accept = ((state_q == IDLE) && rise) || ((state_q == HDR) && data_valid_in);
  assign hdr_last   = (cur_idx == HDR_LAST);
  assign hdr_decode = hdr_accept && hdr_last;

  // Current word merged into the partially collected header.
  always_comb begin
    hdr_d = hdr_q;
    hdr_d[cur_idx*W +: W] = data_in;
  end

  assign vc         = hdr_d[7:6];
  assign dt         = hdr_d[5:0];
  assign wc         = hdr_d[23:8];
  assign is_short   = (dt < 6'h10);
  assign wc_too_big = !is_short && (wc > MAX_WC);
  // Payload plus two CRC bytes, rounded up to whole words.
  assign wc_words   = ({1'b0, wc} + 17'd2 + 17'(NUM_LANE - 1)) >> LOG_NL;

`ifdef CSI_RX_ECC_CHECK_EN
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    calc_ecc[0] = ^(d & 24'hF12CB7);
    calc_ecc[1] = ^(d & 24'hF2555B);
    calc_ecc[2] = ^(d & 24'h749A6D);
    calc_ecc[3] = ^(d & 24'hB8E38E);
    calc_ecc[4] = ^(d & 24'hDF03F0);
    calc_ecc[5] = ^(d & 24'hEFFC00);
  endfunction
  assign ecc_bad = (calc_ecc(hdr_d[23:0]) != hdr_d[29:24]);
`else
  assign ecc_bad = 1'b0;
`endif

  always_comb begin
    lane_be = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      lane_be[i] = vc_ok_q && (({1'b0, byte_cnt_q} + 17'(i)) < {1'b0, wc_q});
    end
  end

  assign byte_cnt_sum = {1'b0, byte_cnt_q} + 17'(NUM_LANE);

  always_comb begin
    hdr_next_state = (ecc_bad || is_short || wc_too_big) ? DONE : PAYLOAD;
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = hdr_last ? hdr_next_state : HDR;
      HDR: begin
        if (!data_valid_in) state_d = DONE;
        else if (hdr_last)  state_d = hdr_next_state;
      end
      PAYLOAD: if (!data_valid_in || (words_left_q <= 16'd1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge byte_clock) begin
    if (reset || !enable) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      hdr_q        <= '0;
      hdr_idx_q    <= '0;
      wc_q         <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      vc_ok_q      <= 1'b0;
      payload_q    <= '0;
      be_q         <= '0;
      data_type_q  <= '0;
      in_frame_q   <= 1'b0;
      in_line_q    <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= data_valid_in;
      hdr_err_q <= 1'b0;
      payload_q <= '0;
      be_q      <= '0;
      if (hdr_accept) begin
        hdr_q     <= hdr_d;
        hdr_idx_q <= cur_idx + 2'd1;
        if (cur_idx == 2'd0) data_type_q <= data_in[5:0];
      end
      if (hdr_decode) begin
        wc_q         <= wc;
        vc_ok_q      <= (vc == VC_SEL);
        byte_cnt_q   <= '0;
        words_left_q <= wc_words[15:0];
        if (ecc_bad || wc_too_big) begin
          hdr_err_q <= 1'b1;
        end else if (is_short && (vc == VC_SEL)) begin
          case (dt)
            6'h00: in_frame_q <= 1'b1;
            6'h01: begin
              in_frame_q <= 1'b0;
              in_line_q  <= 1'b0;
            end
            6'h02: in_line_q <= 1'b1;
            6'h03: in_line_q <= 1'b0;
            default: ;
          endcase
        end
      end
      if ((state_q == PAYLOAD) && data_valid_in) begin
        payload_q    <= data_in;
        be_q         <= lane_be;
        byte_cnt_q   <= byte_cnt_sum[16] ? 16'hFFFF : byte_cnt_sum[15:0];
        words_left_q <= (words_left_q == 16'd0) ? 16'd0 : words_left_q - 16'd1;
      end
    end
  end

  // Outputs are forced idle combinationally while disabled.
  assign wait_for_sync = !enable || (state_q == IDLE);
  assign packet_done   = enable && (state_q == DONE);
  assign payload_out   = enable ? payload_q : '0;
  assign payload_be    = enable ? be_q : '0;
  assign payload_valid = enable && (|be_q);
  assign data_type     = enable ? data_type_q : 6'd0;
  assign in_frame      = enable && in_frame_q;
  assign in_line       = enable && in_line_q;
  assign hdr_err       = enable && hdr_err_q;

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Self-checking bench for csi_rx_packet_handler: packet-level model plus per-cycle payload compare.
module tb_csi_rx_packet_handler;
  localparam int unsigned NL     = 2;
  localparam int unsigned W      = NL * 8;
  localparam int unsigned HW     = 4 / NL;
  localparam logic [1:0]  VC_SEL = 2'd0;
  localparam int unsigned MAX_WC = 8192;
`ifdef CSI_RX_ECC_CHECK_EN
  localparam bit EccEn = 1'b1;
`else
  localparam bit EccEn = 1'b0;
`endif

  logic          byte_clock = 1'b0;
  logic          reset, enable, data_valid_in;
  logic [W-1:0]  data_in;
  logic          wait_for_sync, packet_done, payload_valid, in_frame, in_line, hdr_err;
  logic [W-1:0]  payload_out;
  logic [NL-1:0] payload_be;
  logic [5:0]    data_type;

  csi_rx_packet_handler #(
    .NUM_LANE(NL),
    .VC_SEL  (VC_SEL),
    .MAX_WC  (16'(MAX_WC))
  ) dut (
    .byte_clock   (byte_clock),
    .reset        (reset),
    .enable       (enable),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .wait_for_sync(wait_for_sync),
    .packet_done  (packet_done),
    .payload_out  (payload_out),
    .payload_be   (payload_be),
    .payload_valid(payload_valid),
    .data_type    (data_type),
    .in_frame     (in_frame),
    .in_line      (in_line),
    .hdr_err      (hdr_err)
  );

  always #5 byte_clock = ~byte_clock;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int herr_cnt = 0;
  bit mon_en = 1'b0;
  logic [W+NL-1:0] exp_q[$];
  logic       exp_frame = 1'b0;
  logic       exp_line  = 1'b0;
  logic [5:0] exp_dt    = 6'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int body_words(input int wc);
    return (wc + 2 + NL - 1) / NL;
  endfunction

  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Per-cycle compare of everything the DUT emits against the model's queue.
  logic [W+NL-1:0] mon_e;
  logic [W-1:0]    mon_mask;
  always @(negedge byte_clock) begin
    if (mon_en) begin
      check("valid_vs_be", payload_valid, |payload_be);
      if (packet_done) done_cnt++;
      if (hdr_err) herr_cnt++;
      if (payload_valid) begin
        check("payload_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          for (int i = 0; i < NL; i++) mon_mask[i*8 +: 8] = {8{payload_be[i]}};
          check("payload_be", payload_be, mon_e[W +: NL]);
          check("payload_data", payload_out & mon_mask, mon_e[W-1:0]);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d);
    @(posedge byte_clock);
    #1;
    data_valid_in = v;
    data_in       = d;
  endtask

  // limit: words to send (-1 = whole packet); gap idle words then n_stale valid words follow.
  task automatic send_pkt(input string tag, input logic [7:0] di, input logic [15:0] wc,
                          input bit bad_ecc, input int limit, input int gap, input int n_stale,
                          input logic [7:0] base);
    logic [7:0]    s[$];
    int            start_done, start_err, nbody, full, nsend, nout, exp_err;
    bit            is_short, vc_ok, ecc_fail, wc_err;
    logic [NL-1:0] be;
    logic [W-1:0]  dat, wd;
    start_done = done_cnt;
    start_err  = herr_cnt;
    is_short   = di[5:0] < 6'h10;
    vc_ok      = di[7:6] == VC_SEL;
    ecc_fail   = EccEn && bad_ecc;
    wc_err     = !is_short && (int'(wc) > MAX_WC);
    nbody      = (is_short || wc_err || ecc_fail) ? 0 : body_words(int'(wc));
    full       = HW + nbody;
    nsend      = (limit < 0 || limit > full) ? full : limit;
    s.push_back(di);
    s.push_back(wc[7:0]);
    s.push_back(wc[15:8]);
    s.push_back(ecc_of({wc, di}) ^ {7'd0, bad_ecc});
    for (int k = 0; k < nbody * NL; k++)
      s.push_back(k < int'(wc) ? 8'(int'(base) + k) : 8'(8'hC0 + k - int'(wc)));

    if (nsend >= 1) exp_dt = di[5:0];
    exp_err = (nsend >= HW && (ecc_fail || wc_err)) ? 1 : 0;
    if (nsend >= HW && is_short && vc_ok && !ecc_fail) begin
      case (di[5:0])
        6'h00: exp_frame = 1'b1;
        6'h01: begin exp_frame = 1'b0; exp_line = 1'b0; end
        6'h02: exp_line = 1'b1;
        6'h03: exp_line = 1'b0;
        default: ;
      endcase
    end
    nout = (nsend > HW) ? nsend - HW : 0;
    for (int w = 0; w < nout; w++) begin
      be  = '0;
      dat = '0;
      for (int i = 0; i < NL; i++) begin
        if (vc_ok && (w * NL + i < int'(wc))) begin
          be[i]          = 1'b1;
          dat[i*8 +: 8]  = s[4 + w * NL + i];
        end
      end
      if (be != '0) exp_q.push_back({be, dat});
    end

    for (int k = 0; k < nsend; k++) begin
      for (int i = 0; i < NL; i++) wd[i*8 +: 8] = s[k * NL + i];
      drive(1'b1, wd);
    end
    repeat (gap) drive(1'b0, '0);
    repeat (n_stale) drive(1'b1, {NL{8'hAA}});
    drive(1'b0, '0);
    for (int c = 0; c < 40 && done_cnt == start_done; c++) @(negedge byte_clock);
    repeat (3) @(negedge byte_clock);

    check({tag, ".done_pulses"}, done_cnt - start_done, 1);
    check({tag, ".hdr_err"}, herr_cnt - start_err, exp_err);
    check({tag, ".in_frame"}, in_frame, exp_frame);
    check({tag, ".in_line"}, in_line, exp_line);
    check({tag, ".data_type"}, data_type, exp_dt);
    check({tag, ".wait_for_sync"}, wait_for_sync, 1);
    check({tag, ".payload_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int sd;
    reset = 1'b1;
    enable = 1'b1;
    data_valid_in = 1'b0;
    data_in = '0;
    repeat (3) @(posedge byte_clock);
    #1 reset = 1'b0;
    @(negedge byte_clock);
    check("rst.wait_for_sync", wait_for_sync, 1);
    check("rst.packet_done", packet_done, 0);
    check("rst.payload_valid", payload_valid, 0);
    check("rst.payload_be", payload_be, 0);
    check("rst.flags", {in_frame, in_line, hdr_err}, 0);
    check("rst.data_type", data_type, 0);
    check("model.words_wc10", body_words(10), 6);
    check("model.words_wc5", body_words(5), 4);
    check("model.words_wc0", body_words(0), 1);
    check("model.ecc_zero", ecc_of(24'h0), 8'h00);
    mon_en = 1'b1;

    send_pkt("fs", 8'h00, 16'h0000, 1'b0, -1, 0, 0, 8'h00);
    check("fs.in_frame_lit", in_frame, 1);
    send_pkt("ls", 8'h02, 16'h0000, 1'b0, -1, 0, 0, 8'h00);
    send_pkt("raw10", 8'h2B, 16'h000A, 1'b0, -1, 0, 0, 8'h01);
    check("raw10.dt_lit", data_type, 6'h2B);
    send_pkt("odd_wc", 8'h2B, 16'h0005, 1'b0, -1, 0, 0, 8'h01);
    send_pkt("wc_big", 8'h2B, 16'h3000, 1'b0, -1, 0, 0, 8'h00);
    send_pkt("vc1_long", 8'h6B, 16'h0004, 1'b0, -1, 0, 0, 8'h50);
    send_pkt("vc1_fe", 8'h41, 16'h0000, 1'b0, -1, 0, 0, 8'h00);
    send_pkt("le_stale", 8'h03, 16'h0000, 1'b0, -1, 0, 2, 8'h00);
    send_pkt("after_stale", 8'h2A, 16'h0006, 1'b0, -1, 0, 0, 8'h10);
    send_pkt("wc0", 8'h2B, 16'h0000, 1'b0, -1, 0, 0, 8'h00);
    send_pkt("early_drop", 8'h2B, 16'h000A, 1'b0, 4, 0, 0, 8'h20);
    // Header abort, then a rising valid while in DONE that must be dropped.
    send_pkt("hdr_abort", 8'h12, 16'h0004, 1'b0, 1, 1, 2, 8'h00);
    send_pkt("bad_ecc_ls", 8'h02, 16'h0000, 1'b1, -1, 0, 0, 8'h00);
    send_pkt("fe", 8'h01, 16'h0000, 1'b0, -1, 0, 0, 8'h00);
    send_pkt("wc_max_p1", 8'h2B, 16'(MAX_WC + 1), 1'b0, -1, 0, 0, 8'h00);
    send_pkt("wc_max", 8'h2B, 16'(MAX_WC), 1'b0, -1, 0, 0, 8'h00);
    send_pkt("fs2", 8'h00, 16'h0000, 1'b0, -1, 0, 0, 8'h00);

    // Enable drop mid-header: silent abort, everything cleared.
    sd = done_cnt;
    drive(1'b1, 16'h042B);
    @(posedge byte_clock);
    #1;
    enable = 1'b0;
    data_valid_in = 1'b0;
    @(negedge byte_clock);
    check("en_off.wait_for_sync", wait_for_sync, 1);
    check("en_off.in_frame", in_frame, 0);
    check("en_off.data_type", data_type, 0);
    @(posedge byte_clock);
    #1 enable = 1'b1;
    repeat (3) @(negedge byte_clock);
    check("en_off.no_done", done_cnt - sd, 0);
    check("en_off.in_frame_after", in_frame, 0);
    exp_frame = 1'b0;
    exp_line  = 1'b0;
    exp_dt    = 6'd0;
    send_pkt("fs_recover", 8'h00, 16'h0000, 1'b0, -1, 0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
